// File: rtl/p405s_itlb_miss_ctl_if.sv
// rtl/p405s_itlb_miss_ctl_if.sv - fetch, comparator and UTLB signals of the ITLB miss controller
interface p405s_itlb_miss_ctl_if #(
  parameter int EAW = 22
);
  // Fetch side and comparator results into the controller
  logic           isReq;
  logic [0:EAW-1] isEA;
  logic           msrIrL2;
  logic           isAbort_NEG;
  logic [0:3]     Hit;
  logic           shadowInval;
  logic           utlbAck;
  logic           utlbFault;
  // Controller results, comparator controls and UTLB request
  logic [0:3]     Valid;
  logic           CompE2;
  logic           writeShadow;
  logic [0:1]     writeIndex;
  logic           utlbReq;
  logic [0:EAW-1] utlbEA;
  logic           isHitVal;
  logic [0:1]     hitIndex;
  logic           isMissExc;
  logic           isMultiHitErr;
  logic           isBusy;

  modport master (
    output isReq, isEA, msrIrL2, isAbort_NEG, Hit, shadowInval, utlbAck, utlbFault,
    input  Valid, CompE2, writeShadow, writeIndex, utlbReq, utlbEA,
           isHitVal, hitIndex, isMissExc, isMultiHitErr, isBusy
  );

  modport slave (
    input  isReq, isEA, msrIrL2, isAbort_NEG, Hit, shadowInval, utlbAck, utlbFault,
    output Valid, CompE2, writeShadow, writeIndex, utlbReq, utlbEA,
           isHitVal, hitIndex, isMissExc, isMultiHitErr, isBusy
  );
endinterface

// File: rtl/p405s_itlb_miss_ctl.sv
// rtl/p405s_itlb_miss_ctl.sv - ITLB shadow hit encode, valid ownership and UTLB refill control (option macro: P405S_ITLB_MULTIHIT_CHK_EN)
module p405s_itlb_miss_ctl #(
  parameter int NENT = 4,
  parameter int EAW  = 22
) (
  input logic                   CB,
  input logic                   sysReset_NEG,
  p405s_itlb_miss_ctl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_FILL,
    S_RECMP,
    S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [0:NENT-1] valid_q, valid_d;
  logic [1:0]     rr_q, rr_d;
  logic [0:EAW-1] ea_q, ea_d;

  logic           any_hit;
  logic           multi_hit;
  logic [1:0]     hit_lo;
  logic [1:0]     victim;
  logic           has_free;

  logic           comp_e2;
  logic           write_shadow;
  logic [1:0]     write_index;
  logic           utlb_req;
  logic           hit_val;
  logic [1:0]     hit_index;
  logic           miss_exc;
  logic           multi_err;

  assign any_hit = |bus.Hit;

  // More than one bit set means x & (x-1) is nonzero; with the check disabled the
  // lowest hit is simply taken as a normal hit.
`ifdef P405S_ITLB_MULTIHIT_CHK_EN
  assign multi_hit = (bus.Hit & (bus.Hit - 4'd1)) != 4'd0;
`else
  assign multi_hit = 1'b0;
`endif

  // Binary encode of the lowest-index hit
  always_comb begin
    hit_lo = 2'd0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (bus.Hit[i]) hit_lo = 2'(i);
    end
  end

  // Victim: lowest invalid entry, else the round-robin pointer
  always_comb begin
    victim = rr_q;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim = 2'(i);
    end
  end

  assign has_free = ~&valid_q;

  // Next-state, valid/pointer/EA update and per-state outputs
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    ea_d         = ea_q;
    comp_e2      = 1'b0;
    write_shadow = 1'b0;
    write_index  = 2'd0;
    utlb_req     = 1'b0;
    hit_val      = 1'b0;
    hit_index    = 2'd0;
    miss_exc     = 1'b0;
    multi_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.isReq && bus.msrIrL2) begin
          ea_d    = bus.isEA;
          comp_e2 = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!bus.isAbort_NEG) begin
          state_d = S_IDLE;
        end else if (multi_hit) begin
          multi_err = 1'b1;
          valid_d   = '0;
          state_d   = S_REQ;
        end else if (any_hit) begin
          hit_val   = 1'b1;
          hit_index = hit_lo;
          state_d   = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        utlb_req = 1'b1;
        if (bus.utlbAck) begin
          // An abort arriving with the ack just drops the response.
          if (!bus.isAbort_NEG) begin
            state_d = S_IDLE;
          end else if (bus.utlbFault) begin
            miss_exc = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end else if (!bus.isAbort_NEG) begin
          state_d = S_DRAIN;
        end
      end
      S_FILL: begin
        // The write always completes, even when aborted.
        write_shadow    = 1'b1;
        write_index     = victim;
        valid_d[victim] = 1'b1;
        if (!has_free) rr_d = rr_q + 2'd1;
        state_d = bus.isAbort_NEG ? S_RECMP : S_IDLE;
      end
      S_RECMP: begin
        comp_e2 = 1'b1;
        state_d = bus.isAbort_NEG ? S_LOOKUP : S_IDLE;
      end
      S_DRAIN: begin
        utlb_req = 1'b1;
        if (bus.utlbAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Invalidate overrides any same-cycle fill.
    if (bus.shadowInval) valid_d = '0;
  end

  // State and shadow bookkeeping registers
  always_ff @(posedge CB or negedge sysReset_NEG) begin
    if (!sysReset_NEG) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      rr_q    <= 2'd0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      ea_q    <= ea_d;
    end
  end

  assign bus.Valid         = valid_q;
  assign bus.CompE2        = comp_e2;
  assign bus.writeShadow   = write_shadow;
  assign bus.writeIndex    = write_index;
  assign bus.utlbReq       = utlb_req;
  assign bus.utlbEA        = utlb_req ? ea_q : '0;
  assign bus.isHitVal      = hit_val;
  assign bus.hitIndex      = hit_index;
  assign bus.isMissExc     = miss_exc;
  assign bus.isMultiHitErr = multi_err;
  assign bus.isBusy        = (state_q != S_IDLE);

endmodule
